// File: rtl/axi4_burst_addr_seq.sv
// axi4_burst_addr_seq: AXI4 burst address sequencer, one registered beat per cycle with backpressure.
module axi4_burst_addr_seq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [7:0]              cmd_len_i,
    input  logic [2:0]              cmd_size_i,
    input  logic [1:0]              cmd_burst_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [ADDR_WIDTH-1:0]   beat_addr_o,
    output logic [7:0]              beat_idx_o,
    output logic [DATA_WIDTH/8-1:0] beat_strb_o,
    output logic                    beat_last_o,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3;
    typedef enum logic {IDLE, BURST} state_t;
    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, s_mask, c_mask, cmd_mask, step;
    logic [7:0]              len_q, idx_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [NB-1:0]           strb_q;
    logic                    last_q, err_q, illegal;
    function automatic logic [NB-1:0] lanes(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz);
        logic [NB-1:0]         r;
        logic [ADDR_WIDTH-1:0] al;
        int                    lo, hi;
        al = a & ~((ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1));
        lo = int'(a % ADDR_WIDTH'(NB));
        hi = int'(al % ADDR_WIDTH'(NB)) + (1 << sz) - 1;
        for (int i = 0; i < NB; i++) r[i] = (i >= lo) && (i <= hi);
        return r;
    endfunction
    always_comb begin
        cmd_mask = (ADDR_WIDTH'(1) << cmd_size_i) - ADDR_WIDTH'(1);
        illegal  = (int'(cmd_size_i) > LB) || (cmd_burst_i == RSVD) ||
                   ((cmd_burst_i == WRAP) && (!(cmd_len_i inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                                              ((cmd_addr_i & cmd_mask) != '0)));
        step     = ADDR_WIDTH'(1) << size_q;
        s_mask   = step - ADDR_WIDTH'(1);
        c_mask   = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        addr_d   = (burst_q == FIXED) ? addr_q :
                   (burst_q == INCR)  ? (addr_q & ~s_mask) + step :
                                        (addr_q & ~c_mask) | ((addr_q + step) & c_mask);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == IDLE) begin
                if (cmd_valid_i && illegal) begin
                    err_q <= 1'b1;
                end else if (cmd_valid_i) begin
                    state_q <= BURST;
                    addr_q  <= cmd_addr_i;
                    len_q   <= cmd_len_i;
                    size_q  <= cmd_size_i;
                    burst_q <= cmd_burst_i;
                    idx_q   <= '0;
                    strb_q  <= lanes(cmd_addr_i, cmd_size_i);
                    last_q  <= (cmd_len_i == 8'd0);
                end
            end else if (beat_ready_i) begin
                if (last_q) begin
                    state_q <= IDLE;
                    last_q  <= 1'b0;
                end else begin
                    addr_q <= addr_d;
                    idx_q  <= idx_q + 8'd1;
                    strb_q <= lanes(addr_d, size_q);
                    last_q <= (idx_q + 8'd1) == len_q;
                end
            end
        end
    end
    assign cmd_ready_o  = (state_q == IDLE);
    assign beat_valid_o = (state_q == BURST);
    assign busy_o       = (state_q == BURST);
    assign beat_addr_o  = addr_q;
    assign beat_idx_o   = idx_q;
    assign beat_strb_o  = strb_q;
    assign beat_last_o  = last_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_axi4_burst_addr_seq.sv
// tb_axi4_burst_addr_seq: directed and randomized bursts checked against a list-of-beats reference model.
module tb_axi4_burst_addr_seq;
    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_ready_o;
    logic [15:0] cmd_addr_i = '0;
    logic [7:0]  cmd_len_i = '0;
    logic [2:0]  cmd_size_i = '0;
    logic [1:0]  cmd_burst_i = '0;
    logic        beat_valid_o, beat_ready_i = 1'b0;
    logic [15:0] beat_addr_o;
    logic [7:0]  beat_idx_o;
    logic [7:0]  beat_strb_o;
    logic        beat_last_o, busy_o, err_o;
    int          n_chk = 0, n_pass = 0;
    int          exp_addr[$], exp_strb[$];
    bit          exp_legal;
    axi4_burst_addr_seq #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_size_i(cmd_size_i), .cmd_burst_i(cmd_burst_i),
        .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
        .beat_addr_o(beat_addr_o), .beat_idx_o(beat_idx_o), .beat_strb_o(beat_strb_o),
        .beat_last_o(beat_last_o), .busy_o(busy_o), .err_o(err_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    task automatic model(input int addr, input int len, input int size, input int burst);
        int s, a, c, b, lo, hi, m;
        s = 1 << size;
        exp_addr.delete();
        exp_strb.delete();
        exp_legal = !(s > 8 || burst == 3 ||
                      (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
                      (burst == 2 && addr % s != 0));
        if (!exp_legal) return;
        a = addr;
        for (int k = 0; k <= len; k++) begin
            lo = a % 8;
            hi = (a / s * s) % 8 + s - 1;
            m = 0;
            for (int l = lo; l <= hi; l++) m |= 1 << l;
            exp_addr.push_back(a);
            exp_strb.push_back(m);
            if (burst == 1) a = (a / s * s + s) % 65536;
            else if (burst == 2) begin
                c = s * (len + 1);
                b = a / c * c;
                a = a + s;
                if (a == b + c) a = b;
            end
        end
    endtask
    task automatic junk_cmd();
        cmd_valid_i = 1'($urandom);
        cmd_addr_i  = 16'($urandom);
        cmd_len_i   = 8'($urandom);
        cmd_size_i  = 3'($urandom);
        cmd_burst_i = 2'($urandom);
    endtask
    task automatic run_cmd(input int addr, input int len, input int size, input int burst,
                           input int stall0, input bit rnd);
        int stalls;
        model(addr, len, size, burst);
        chk("idle_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 16'(addr);
        cmd_len_i   = 8'(len);
        cmd_size_i  = 3'(size);
        cmd_burst_i = 2'(burst);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (!exp_legal) begin
            chk("err_pulse", err_o, 1);
            chk("err_no_beat", beat_valid_o, 0);
            chk("err_ready", cmd_ready_o, 1);
            @(posedge clk); #1;
            chk("err_one_cycle", err_o, 0);
            chk("err_no_beat2", beat_valid_o, 0);
            return;
        end
        for (int k = 0; k <= len; k++) begin
            stalls = 0;
            forever begin
                chk("beat_valid", beat_valid_o, 1);
                chk("beat_addr", beat_addr_o, 32'(exp_addr[k]));
                chk("beat_idx", beat_idx_o, 32'(k));
                chk("beat_strb", beat_strb_o, 32'(exp_strb[k]));
                chk("beat_last", beat_last_o, 32'(k == len));
                chk("busy_ready", {busy_o, cmd_ready_o, err_o}, 3'b100);
                junk_cmd();
                beat_ready_i = (k == 0 && stalls < stall0) ? 1'b0 :
                               (rnd && stalls < 3) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
                stalls++;
                @(posedge clk); #1;
                if (beat_ready_i) break;
            end
        end
        beat_ready_i = 1'b0;
        cmd_valid_i  = 1'b0;
        chk("turnaround_ready", cmd_ready_o, 1);
        chk("end_valid", {beat_valid_o, busy_o}, 2'b00);
    endtask
    initial begin
        int a, l, s, b;
        #2;
        chk("rst_outputs", {cmd_ready_o, beat_valid_o, beat_last_o, busy_o, err_o}, 5'b10000);
        chk("rst_beat", {beat_addr_o, beat_idx_o, beat_strb_o}, 32'd0);
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {cmd_ready_o, err_o}, 2'b10);
        run_cmd('h1003, 3, 2, 1, 0, 0);
        run_cmd('h0038, 3, 3, 2, 0, 0);
        run_cmd('h0102, 2, 1, 0, 0, 0);
        run_cmd('hFFF8, 1, 3, 1, 3, 0);
        run_cmd('h0000, 0, 4, 1, 0, 0);
        run_cmd('h0000, 2, 2, 2, 0, 0);
        run_cmd('h0000, 0, 0, 3, 0, 0);
        run_cmd('h0004, 3, 3, 2, 0, 0);
        run_cmd('h00F0, 0, 0, 1, 0, 0);
        cmd_valid_i = 1'b1; cmd_addr_i = '0; cmd_len_i = 8'd7; cmd_size_i = 3'd3; cmd_burst_i = 2'd1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        chk("abort_beat0", beat_addr_o, 'h0000);
        beat_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("abort_beat1", beat_addr_o, 'h0008);
        rst_n_i = 1'b0;
        #1;
        chk("abort_valid", {beat_valid_o, busy_o, cmd_ready_o}, 3'b001);
        chk("abort_clear", {beat_addr_o, beat_idx_o, beat_strb_o}, 32'd0);
        beat_ready_i = 1'b0;
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        @(posedge clk); #1;
        run_cmd('h0040, 3, 3, 1, 0, 0);
        for (int t = 0; t < 80; t++) begin
            b = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            s = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
            a = $urandom_range(0, 65535);
            if (b == 2) begin
                l = (1 << $urandom_range(1, 4)) - 1;
                if ($urandom_range(0, 9) == 0) l = $urandom_range(0, 15);
                if ($urandom_range(0, 9) != 0) a = a & ~((1 << s) - 1);
            end else l = $urandom_range(0, 20);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("gap_idle", {cmd_ready_o, beat_valid_o, err_o}, 3'b100);
            end
            run_cmd(a, l, s, b, 0, 1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
